// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise-op arbiter.
//   - logicOpE  : operation encodings presented on reqN_op
//   - arbStateE : FSM state encodings used by logic_op_arbiter
//   - DEFAULT_WIDTH : default operand/result width
package logic_op_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } logicOpE;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arbStateE;

endpackage

// File: rtl/logic_unit_16_bit.sv
// Purely combinational bitwise logic unit.
// Ports:
//   a, b : operands (WIDTH bits)
//   op   : operation select (AND / OR / XOR / NOR)
//   res  : bitwise result, no carry or sign extension
module logic_unit_16_bit
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (logicOpE'(op))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Time-shares one bitwise logic unit between two requesters.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   reqN_valid/reqN_ready  : request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op: operands and operation for requester N
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id                 : requester that owns the current result
//   rsp_data, rsp_zero     : registered result and its all-zero flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grant by valid / round-robin pointer
// EXEC  | captured operands run through the logic unit, result registered
// RESP  | result presented until rsp_ready
module logic_op_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
);

    arbStateE         state;
    arbStateE         stateNext;
    logic             rrPtr;
    logic             grantId;
    logic             handshake;
    logic [WIDTH-1:0] capA;
    logic [WIDTH-1:0] capB;
    logic [1:0]       capOp;
    logic             capId;
    logic [WIDTH-1:0] rspDataReg;
    logic             rspZeroReg;
    logic [WIDTH-1:0] unitRes;

    // Pointer only breaks ties; a lone valid always wins.
    always_comb begin
        grantId = rrPtr;
        if (!(req0_valid && req1_valid)) begin
            grantId = !req0_valid;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (handshake) stateNext = EXEC;
            EXEC:    stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic. Ready is masked while reset is held so nothing can be
    // accepted on the very edge that clears the block.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        if (state == IDLE && rst_n) begin
            req0_ready = req0_valid && !grantId;
            req1_ready = req1_valid &&  grantId;
        end
        if (state == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    assign handshake = req0_ready || req1_ready;

    // Capture and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtr      <= 1'b0;
            capA       <= '0;
            capB       <= '0;
            capOp      <= 2'b00;
            capId      <= 1'b0;
            rspDataReg <= '0;
            rspZeroReg <= 1'b0;
        end else begin
            if (handshake) begin
                capA  <= grantId ? req1_a  : req0_a;
                capB  <= grantId ? req1_b  : req0_b;
                capOp <= grantId ? req1_op : req0_op;
                capId <= grantId;
                rrPtr <= !grantId;
            end
            if (state == EXEC) begin
                rspDataReg <= unitRes;
                rspZeroReg <= (unitRes == '0);
            end
        end
    end

    logic_unit_16_bit #(.WIDTH(WIDTH)) uLogicUnit (
        .a   (capA),
        .b   (capB),
        .op  (capOp),
        .res (unitRes)
    );

    assign rsp_id   = capId;
    assign rsp_data = rspDataReg;
    assign rsp_zero = rspZeroReg;

endmodule
